// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus the ALU drive/return bus for alu_issue_ctrl.
// Latency: none, wires only.
// Backpressure: INSTR_READY is the only stall signal on this bus.
interface alu_issue_ctrl_if;
  logic        INSTR_VALID;
  logic [15:0] INSTR;
  logic        INSTR_READY;
  logic        ALU_EN;
  logic        ALU_OE;
  logic [3:0]  ALU_OPCODE;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [7:0]  ALU_OUT;
  logic        CF;
  logic        OF;
  logic        SF;
  logic        ZF;

  // Controller side.
  modport slave (
    input  INSTR_VALID, INSTR, ALU_OUT, CF, OF, SF, ZF,
    output INSTR_READY, ALU_EN, ALU_OE, ALU_OPCODE, ALU_A, ALU_B
  );

  // Instruction source and ALU side.
  modport master (
    output INSTR_VALID, INSTR, ALU_OUT, CF, OF, SF, ZF,
    input  INSTR_READY, ALU_EN, ALU_OE, ALU_OPCODE, ALU_A, ALU_B
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for an 8-bit ALU with a 4 x 8-bit register file.
// Latency: LDI/illegal retire in 1 cycle; ALU ops write back ALU_LAT+1 edges after handshake.
// Backpressure: INSTR_READY is high only in IDLE; a pending instruction waits there.
module alu_issue_ctrl #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             CLK,
  input  logic             RST,
  alu_issue_ctrl_if.slave  bus,
  output logic [3:0]       FLAGS,
  output logic             DONE,
  output logic             ERR,
  input  logic [1:0]       RD_SEL,
  output logic [7:0]       RD_DATA
);

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [2:0] CNT_INIT = 3'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [3:0][7:0] rf_q;
  logic [3:0][7:0] rf_d;
  logic [3:0]      flags_q;
  logic            done_q;
  logic            err_q;
  logic            en_q;
  logic            oe_q;
  logic [3:0]      opc_q;
  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic [1:0]      rd_q;

  // Instruction field decode.
  logic [3:0] ins_op;
  logic [1:0] ins_rd;
  logic [1:0] ins_ra;
  logic [1:0] ins_rb;
  logic [7:0] ins_imm;
  logic       is_ldi;
  logic       is_alu;
  logic       hs;
  logic       wb;

  assign ins_op  = bus.INSTR[15:12];
  assign ins_rd  = bus.INSTR[11:10];
  assign ins_ra  = bus.INSTR[9:8];
  assign ins_rb  = bus.INSTR[7:6];
  assign ins_imm = bus.INSTR[7:0];
  assign is_ldi  = (ins_op == OP_LDI);
  assign is_alu  = (ins_op >= OP_ADD) && (ins_op <= OP_NOT);
  assign hs      = bus.INSTR_VALID && (state_q == S_IDLE);
  assign wb      = (state_q == S_WAIT) && (cnt_q == 3'd0);

  assign bus.INSTR_READY = (state_q == S_IDLE);
  assign bus.ALU_EN      = en_q;
  assign bus.ALU_OE      = oe_q;
  assign bus.ALU_OPCODE  = opc_q;
  assign bus.ALU_A       = a_q;
  assign bus.ALU_B       = b_q;
  assign FLAGS           = flags_q;
  assign DONE            = done_q;
  assign ERR             = err_q;
  assign RD_DATA         = rf_q[RD_SEL];

  // Register-file next state: LDI at handshake or ALU result at writeback, never both.
  always_comb begin
    rf_d = rf_q;
    if (hs && is_ldi) begin
      rf_d[ins_rd] = ins_imm;
    end else if (wb) begin
      rf_d[rd_q] = bus.ALU_OUT;
    end
  end

  // Register file storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_q <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Issue FSM with registered ALU drive, flags and retire/error pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      flags_q <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      oe_q    <= 1'b0;
      opc_q   <= 4'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      rd_q    <= 2'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.INSTR_VALID) begin
            if (is_ldi) begin
              done_q <= 1'b1;
            end else if (is_alu) begin
              // Operands come from the pre-instruction register file.
              opc_q   <= ins_op;
              a_q     <= rf_q[ins_ra];
              b_q     <= rf_q[ins_rb];
              rd_q    <= ins_rd;
              en_q    <= 1'b1;
              oe_q    <= 1'b0;
              state_q <= S_ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          oe_q    <= 1'b1;
          cnt_q   <= CNT_INIT;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 3'd0) begin
            flags_q <= {bus.CF, bus.OF, bus.SF, bus.ZF};
            done_q  <= 1'b1;
            en_q    <= 1'b0;
            oe_q    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with ALU_LAT=1, one with ALU_LAT=3.
// Latency: a bench-side 8-bit ALU returns results combinationally while OE is high.
// Backpressure: instructions are only presented when the selected controller is expected idle.
module tb_alu_issue_ctrl;

  logic        CLK;
  logic        RST;
  logic        valid;
  logic [15:0] instr;
  logic [1:0]  rd_sel;
  logic        use3;

  int n_vec;
  int n_bad;

  alu_issue_ctrl_if bus1 ();
  alu_issue_ctrl_if bus3 ();

  logic [3:0] flags1, flags3;
  logic       done1, done3, err1, err3;
  logic [7:0] rdd1, rdd3;

  alu_issue_ctrl #(.ALU_LAT(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .bus(bus1.slave),
    .FLAGS(flags1), .DONE(done1), .ERR(err1),
    .RD_SEL(rd_sel), .RD_DATA(rdd1)
  );

  alu_issue_ctrl #(.ALU_LAT(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .bus(bus3.slave),
    .FLAGS(flags3), .DONE(done3), .ERR(err3),
    .RD_SEL(rd_sel), .RD_DATA(rdd3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference 8-bit ALU: returns {CF,OF,SF,ZF,result}.
  function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       cf;
    logic       of;
    s  = 9'd0;
    cf = 1'b0;
    of = 1'b0;
    case (op)
      4'h2: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; cf = s[8]; of = (a[7] == b[7]) && (r[7] != a[7]); end
      4'h3: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; cf = s[8]; of = (a[7] != b[7]) && (r[7] != a[7]); end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      default: r = 8'd0;
    endcase
    return {cf, of, r[7], (r == 8'd0), r};
  endfunction

  logic [11:0] alu1, alu3;
  assign alu1 = bus1.ALU_OE ? alu_f(bus1.ALU_OPCODE, bus1.ALU_A, bus1.ALU_B) : 12'd0;
  assign alu3 = bus3.ALU_OE ? alu_f(bus3.ALU_OPCODE, bus3.ALU_A, bus3.ALU_B) : 12'd0;

  assign bus1.INSTR_VALID = valid & ~use3;
  assign bus1.INSTR       = instr;
  assign bus1.ALU_OUT     = alu1[7:0];
  assign {bus1.CF, bus1.OF, bus1.SF, bus1.ZF} = alu1[11:8];
  assign bus3.INSTR_VALID = valid & use3;
  assign bus3.INSTR       = instr;
  assign bus3.ALU_OUT     = alu3[7:0];
  assign {bus3.CF, bus3.OF, bus3.SF, bus3.ZF} = alu3[11:8];

  // Observation mux onto whichever controller is under test.
  logic       o_ready, o_en, o_oe, o_done, o_err;
  logic [3:0] o_opc, o_flags;
  logic [7:0] o_a, o_b, o_rd;
  always_comb begin
    o_ready = use3 ? bus3.INSTR_READY : bus1.INSTR_READY;
    o_en    = use3 ? bus3.ALU_EN      : bus1.ALU_EN;
    o_oe    = use3 ? bus3.ALU_OE      : bus1.ALU_OE;
    o_opc   = use3 ? bus3.ALU_OPCODE  : bus1.ALU_OPCODE;
    o_a     = use3 ? bus3.ALU_A       : bus1.ALU_A;
    o_b     = use3 ? bus3.ALU_B       : bus1.ALU_B;
    o_done  = use3 ? done3            : done1;
    o_err   = use3 ? err3             : err1;
    o_flags = use3 ? flags3           : flags1;
    o_rd    = use3 ? rdd3             : rdd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    @(negedge CLK);
    rd_sel = sel;
    #1;
    chk(tag, 32'(o_rd), 32'(exp));
  endtask

  task automatic do_issue(input logic [15:0] ins);
    @(negedge CLK);
    instr = ins;
    valid = 1'b1;
    #1;
    chk("ready_at_issue", 32'(o_ready), 32'd1);
    @(posedge CLK);
    #1;
    valid = 1'b0;
  endtask

  task automatic ldi(input string tag, input logic [15:0] ins);
    do_issue(ins);
    @(negedge CLK);
    chk({tag, "_done"}, 32'(o_done), 32'd1);
    chk({tag, "_err"}, 32'(o_err), 32'd0);
  endtask

  // Drives an ALU op and checks the EN/OE/READY/DONE profile cycle by cycle,
  // the held operands, and the written-back register and flags.
  task automatic alu_op(input string tag, input logic [15:0] ins, input logic [7:0] ea,
                        input logic [7:0] eb, input logic [7:0] eres, input logic [3:0] eflg);
    int lat;
    lat = use3 ? 3 : 1;
    do_issue(ins);
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge CLK);
      chk({tag, "_en"},    32'(o_en),    32'(c <= lat));
      chk({tag, "_oe"},    32'(o_oe),    32'(c >= 1 && c <= lat));
      chk({tag, "_ready"}, 32'(o_ready), 32'(c == lat + 1));
      chk({tag, "_done"},  32'(o_done),  32'(c == lat + 1));
      chk({tag, "_opc"},   32'(o_opc),   32'(ins[15:12]));
      chk({tag, "_a"},     32'(o_a),     32'(ea));
      chk({tag, "_b"},     32'(o_b),     32'(eb));
    end
    rd_chk({tag, "_res"}, ins[11:10], eres);
    chk({tag, "_flags"}, 32'(o_flags), 32'(eflg));
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    RST    = 1'b1;
    valid  = 1'b0;
    instr  = 16'd0;
    rd_sel = 2'd0;
    use3   = 1'b0;

    // Reset state.
    repeat (2) @(negedge CLK);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_en",    32'(o_en),    32'd0);
    chk("rst_oe",    32'(o_oe),    32'd0);
    chk("rst_opc",   32'(o_opc),   32'd0);
    chk("rst_a",     32'(o_a),     32'd0);
    chk("rst_b",     32'(o_b),     32'd0);
    chk("rst_flags", 32'(o_flags), 32'd0);
    chk("rst_done",  32'(o_done),  32'd0);
    chk("rst_err",   32'(o_err),   32'd0);
    chk("rst_rf0",   32'(o_rd),    32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Back-to-back LDI r0=255, r1=255.
    instr = 16'h10FF;
    valid = 1'b1;
    #1;
    chk("ldi_bb_ready0", 32'(o_ready), 32'd1);
    @(posedge CLK);
    #1;
    instr = 16'h14FF;
    @(negedge CLK);
    chk("ldi_bb_done0",  32'(o_done),  32'd1);
    chk("ldi_bb_ready1", 32'(o_ready), 32'd1);
    @(posedge CLK);
    #1;
    valid = 1'b0;
    @(negedge CLK);
    chk("ldi_bb_done1", 32'(o_done), 32'd1);
    @(negedge CLK);
    chk("ldi_bb_done_end", 32'(o_done), 32'd0);
    rd_chk("ldi_r0", 2'd0, 8'd255);
    rd_chk("ldi_r1", 2'd1, 8'd255);

    // ADD r2,r0,r1: 255+255 -> 254, carry out.
    alu_op("add_ff", {4'h2, 2'd2, 2'd0, 2'd1, 6'd0}, 8'd255, 8'd255, 8'd254, 4'b1010);

    // 103 + 30 = 133: signed overflow, negative, no carry.
    ldi("ldi_103", 16'h1067);
    ldi("ldi_30",  16'h141E);
    alu_op("add_ovf", {4'h2, 2'd3, 2'd0, 2'd1, 6'd0}, 8'd103, 8'd30, 8'd133, 4'b0110);
    // XOR r3,r3,r3 reads r3 before it is overwritten.
    alu_op("xor_self", {4'h6, 2'd3, 2'd3, 2'd3, 6'd0}, 8'd133, 8'd133, 8'd0, 4'b0001);

    // Illegal opcodes: ERR pulse only.
    do_issue(16'h9000);
    @(negedge CLK);
    chk("ill9_err",   32'(o_err),   32'd1);
    chk("ill9_done",  32'(o_done),  32'd0);
    chk("ill9_en",    32'(o_en),    32'd0);
    chk("ill9_ready", 32'(o_ready), 32'd1);
    @(negedge CLK);
    chk("ill9_err_end", 32'(o_err), 32'd0);
    chk("ill9_flags",   32'(o_flags), 32'b0001);
    rd_chk("ill9_r2", 2'd2, 8'd254);
    rd_chk("ill9_r3", 2'd3, 8'd0);
    do_issue(16'h0000);
    @(negedge CLK);
    chk("ill0_err", 32'(o_err), 32'd1);
    chk("ill0_en",  32'(o_en),  32'd0);

    // AND r2,r0,r1 with LDI r3=0x55 held valid behind it.
    @(negedge CLK);
    rd_sel = 2'd3;
    instr  = {4'h4, 2'd2, 2'd0, 2'd1, 6'd0};
    valid  = 1'b1;
    @(posedge CLK);
    #1;
    instr = 16'h1C55;
    @(negedge CLK);
    chk("hold_c0_ready", 32'(o_ready), 32'd0);
    chk("hold_c0_r3",    32'(o_rd),    32'd0);
    @(negedge CLK);
    chk("hold_c1_ready", 32'(o_ready), 32'd0);
    chk("hold_c1_done",  32'(o_done),  32'd0);
    chk("hold_c1_r3",    32'(o_rd),    32'd0);
    @(negedge CLK);
    chk("hold_wb_done",  32'(o_done),  32'd1);
    chk("hold_wb_ready", 32'(o_ready), 32'd1);
    chk("hold_wb_r3",    32'(o_rd),    32'd0);
    @(posedge CLK);
    #1;
    valid = 1'b0;
    @(negedge CLK);
    chk("hold_ldi_done", 32'(o_done), 32'd1);
    chk("hold_ldi_r3",   32'(o_rd),   32'h55);
    chk("hold_flags",    32'(o_flags), 32'b0000);
    rd_chk("hold_and_r2", 2'd2, 8'd6);

    // Reset during WAIT of SUB r1,r1,r0 aborts the writeback.
    do_issue({4'h3, 2'd1, 2'd1, 2'd0, 6'd0});
    @(negedge CLK);
    chk("abort_issue_en", 32'(o_en), 32'd1);
    @(negedge CLK);
    chk("abort_wait_oe", 32'(o_oe), 32'd1);
    RST = 1'b1;
    #1;
    chk("abort_en",    32'(o_en),    32'd0);
    chk("abort_oe",    32'(o_oe),    32'd0);
    chk("abort_opc",   32'(o_opc),   32'd0);
    chk("abort_a",     32'(o_a),     32'd0);
    chk("abort_b",     32'(o_b),     32'd0);
    chk("abort_flags", 32'(o_flags), 32'd0);
    chk("abort_ready", 32'(o_ready), 32'd1);
    @(negedge CLK);
    RST   = 1'b0;
    instr = 16'h183C;
    valid = 1'b1;
    @(posedge CLK);
    #1;
    valid = 1'b0;
    @(negedge CLK);
    chk("post_rst_done", 32'(o_done), 32'd1);
    rd_chk("post_rst_r0", 2'd0, 8'd0);
    rd_chk("post_rst_r1", 2'd1, 8'd0);
    rd_chk("post_rst_r2", 2'd2, 8'h3C);
    rd_chk("post_rst_r3", 2'd3, 8'd0);

    // ALU_LAT=3 instance.
    use3 = 1'b1;
    ldi("l3_ldi_r0", 16'h1080);
    ldi("l3_ldi_r1", 16'h1480);
    alu_op("l3_add", {4'h2, 2'd2, 2'd0, 2'd1, 6'd0}, 8'h80, 8'h80, 8'h00, 4'b1101);
    alu_op("l3_not", {4'h7, 2'd3, 2'd2, 2'd1, 6'd0}, 8'h00, 8'h80, 8'hFF, 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
